// File: rtl/rf_mp_init_if.sv
// rtl/rf_mp_init_if.sv - port bundle for the rf_mp_init register file
// Signals (RD_N read ports, WR_N write ports, AW address bits, W data bits):
//   init_req  master->slave  pulse: rerun the clear sequence
//   busy      slave->master  clear sequence in progress
//   ra, ren   master->slave  per-port read address / read enable
//   rdata     slave->master  per-port read data
//   rvld      slave->master  per-port read data valid
//   wa, wen   master->slave  per-port write address / write enable
//   wdata     master->slave  per-port write data
interface rf_mp_init_if #(
  parameter int W    = 32,
  parameter int AW   = 3,
  parameter int WR_N = 2,
  parameter int RD_N = 2
);
  logic                 init_req;
  logic                 busy;
  logic [RD_N*AW-1:0]   ra;
  logic [RD_N-1:0]      ren;
  logic [RD_N*W-1:0]    rdata;
  logic [RD_N-1:0]      rvld;
  logic [WR_N*AW-1:0]   wa;
  logic [WR_N-1:0]      wen;
  logic [WR_N*W-1:0]    wdata;

  modport master (
    output init_req, ra, ren, wa, wen, wdata,
    input  busy, rdata, rvld
  );

  modport slave (
    input  init_req, ra, ren, wa, wen, wdata,
    output busy, rdata, rvld
  );
endinterface

// File: rtl/rf_mp_init.sv
// rtl/rf_mp_init.sv - multi-port register file with hardware clear sequencer
// Ports:
//   clk               clock
//   rst               synchronous active-low reset
//   bus.init_req      pulse: rerun the clear sequence (soft clear)
//   bus.busy          clear sequence in progress; all ports inert
//   bus.ra / ren      per read port address / enable
//   bus.rdata / rvld  per read port data / valid
//   bus.wa / wen      per write port address / enable
//   bus.wdata         per write port data
module rf_mp_init #(
  parameter int           W        = 32,
  parameter int           N        = 8,
  parameter int           WR_N     = 2,
  parameter int           RD_N     = 2,
  parameter int           FLOP_OUT = 0,
  parameter int           BYPASS   = 1,
  parameter logic [W-1:0] INIT_VAL = '0
) (
  input logic         clk,
  input logic         rst,
  rf_mp_init_if.slave bus
);
  localparam int            AW       = (N > 1) ? $clog2(N) : 1;
  localparam logic [AW-1:0] CNT_LAST = AW'(N - 1);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          busy;

  logic [W-1:0]  mem [N];

  logic [AW-1:0] wa_p   [WR_N];
  logic [W-1:0]  wd_p   [WR_N];
  logic [WR_N-1:0] wr_ok;
  logic [AW-1:0] ra_p   [RD_N];
  logic [W-1:0]  rd_val [RD_N];

  assign busy     = (state_q == ST_INIT);
  assign bus.busy = busy;

  // Per-port views of the packed address/data buses. Out-of-range write
  // addresses are filtered here so they can neither land nor bypass.
  for (genvar j = 0; j < WR_N; j++) begin : g_wr
    assign wa_p[j]  = bus.wa[j*AW +: AW];
    assign wd_p[j]  = bus.wdata[j*W +: W];
    assign wr_ok[j] = bus.wen[j] && (int'(wa_p[j]) < N);
  end

  for (genvar i = 0; i < RD_N; i++) begin : g_rd
    assign ra_p[i] = bus.ra[i*AW +: AW];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_INIT: begin
        if (bus.init_req) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      ST_RUN: begin
        if (bus.init_req) begin
          state_d = ST_INIT;
          cnt_d   = '0;
        end
      end
    endcase
  end

  // The array itself is never reset: the sequencer clears it entry by entry,
  // which keeps it mappable onto plain storage. Ports are applied in
  // ascending order so the highest-indexed port wins an address collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (busy) begin
        mem[cnt_q] <= INIT_VAL;
      end else begin
        for (int j = 0; j < WR_N; j++) begin
          if (wr_ok[j]) mem[wa_p[j]] <= wd_p[j];
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < RD_N; i++) begin
      rd_val[i] = '0;
      if (int'(ra_p[i]) < N) begin
        rd_val[i] = mem[ra_p[i]];
        if (BYPASS != 0) begin
          for (int j = 0; j < WR_N; j++) begin
            if (wr_ok[j] && (wa_p[j] == ra_p[i])) rd_val[i] = wd_p[j];
          end
        end
      end
    end
  end

  if (FLOP_OUT != 0) begin : g_flop
    logic [RD_N*W-1:0] rdata_q;
    logic [RD_N-1:0]   rvld_q;
    logic              load_ok;

    // Reads only load while the file stays in RUN across the edge; entering
    // or sitting in INIT forces the registered outputs to zero so nothing
    // stale is visible while busy.
    assign load_ok = (state_q == ST_RUN) && (state_d == ST_RUN);

    always_ff @(posedge clk) begin
      if (!rst) begin
        rdata_q <= '0;
        rvld_q  <= '0;
      end else begin
        for (int i = 0; i < RD_N; i++) begin
          rvld_q[i] <= bus.ren[i] & load_ok;
          if (!load_ok) begin
            rdata_q[i*W +: W] <= '0;
          end else if (bus.ren[i]) begin
            rdata_q[i*W +: W] <= rd_val[i];
          end
        end
      end
    end

    assign bus.rdata = rdata_q;
    assign bus.rvld  = rvld_q;
  end else begin : g_comb
    for (genvar i = 0; i < RD_N; i++) begin : g_out
      assign bus.rdata[i*W +: W] = busy ? '0 : rd_val[i];
    end
    assign bus.rvld = bus.ren & {RD_N{~busy}};
  end
endmodule

// File: tb/tb_rf_mp_init.sv
// tb/tb_rf_mp_init.sv - scoreboard bench: dut_a N=8 comb/bypass, dut_b N=6 flopped/no bypass
module tb_rf_mp_init;
  localparam int W  = 32;
  localparam int AW = 3;
  localparam logic [W-1:0] IV_A = 32'h5A5A_0000;
  localparam logic [W-1:0] IV_B = 32'h0000_C0DE;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b;

  rf_mp_init_if #(.W(W), .AW(AW), .WR_N(2), .RD_N(2)) ifa ();
  rf_mp_init_if #(.W(W), .AW(AW), .WR_N(2), .RD_N(2)) ifb ();

  rf_mp_init #(.W(W), .N(8), .WR_N(2), .RD_N(2), .FLOP_OUT(0), .BYPASS(1),
               .INIT_VAL(IV_A)) dut_a (.clk(clk), .rst(rst_a), .bus(ifa.slave));
  rf_mp_init #(.W(W), .N(6), .WR_N(2), .RD_N(2), .FLOP_OUT(1), .BYPASS(0),
               .INIT_VAL(IV_B)) dut_b (.clk(clk), .rst(rst_b), .bus(ifb.slave));

  int checks = 0;
  int failures = 0;
  logic [W-1:0] mdl_a [8];
  logic [W-1:0] mdl_b [6];
  logic [W-1:0] exp_q [$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_a();
    ifa.init_req = 1'b0; ifa.ren = '0; ifa.wen = '0;
    ifa.ra = '0; ifa.wa = '0; ifa.wdata = '0;
  endtask

  task automatic clr_b();
    ifb.init_req = 1'b0; ifb.ren = '0; ifb.wen = '0;
    ifb.ra = '0; ifb.wa = '0; ifb.wdata = '0;
  endtask

  task automatic set_rd_a(input int p, input logic [AW-1:0] a);
    ifa.ren[p] = 1'b1; ifa.ra[p*AW +: AW] = a;
  endtask

  task automatic set_wr_a(input int p, input logic [AW-1:0] a, input logic [W-1:0] d);
    ifa.wen[p] = 1'b1; ifa.wa[p*AW +: AW] = a; ifa.wdata[p*W +: W] = d;
  endtask

  task automatic set_rd_b(input int p, input logic [AW-1:0] a);
    ifb.ren[p] = 1'b1; ifb.ra[p*AW +: AW] = a;
  endtask

  task automatic set_wr_b(input int p, input logic [AW-1:0] a, input logic [W-1:0] d);
    ifb.wen[p] = 1'b1; ifb.wa[p*AW +: AW] = a; ifb.wdata[p*W +: W] = d;
  endtask

  task automatic test_reset();
    int n_a, n_b;
    logic [W-1:0] want;
    clr_a(); clr_b();
    rst_a = 1'b0; rst_b = 1'b0;
    tick(); tick();
    checks++;
    if (ifa.busy !== 1'b1) begin
      failures++; $display("FAIL reset_busy_a got=%b exp=1", ifa.busy);
    end
    checks++;
    if (ifb.rvld !== 2'b00 || ifb.rdata !== '0) begin
      failures++; $display("FAIL reset_out_b rvld=%b rdata=%h exp=0", ifb.rvld, ifb.rdata);
    end
    rst_a = 1'b1; rst_b = 1'b1;
    ifa.ren = 2'b11; ifb.ren = 2'b11;
    n_a = 0; n_b = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (ifa.busy === 1'b1) begin
        n_a++; checks++;
        if (ifa.rvld !== 2'b00 || ifa.rdata !== '0) begin
          failures++; $display("FAIL busy_out_a rvld=%b rdata=%h exp=0", ifa.rvld, ifa.rdata);
        end
      end
      if (ifb.busy === 1'b1) begin
        n_b++; checks++;
        if (ifb.rvld !== 2'b00 || ifb.rdata !== '0) begin
          failures++; $display("FAIL busy_out_b rvld=%b rdata=%h exp=0", ifb.rvld, ifb.rdata);
        end
      end
      tick();
    end
    checks++;
    if (n_a != 8) begin failures++; $display("FAIL busy_len_a got=%0d exp=8", n_a); end
    checks++;
    if (n_b != 6) begin failures++; $display("FAIL busy_len_b got=%0d exp=6", n_b); end
    for (int i = 0; i < 8; i++) mdl_a[i] = IV_A;
    for (int i = 0; i < 6; i++) mdl_b[i] = IV_B;
    clr_a(); clr_b();
    for (int k = 0; k < 4; k++) begin
      set_rd_a(0, AW'(k)); set_rd_a(1, AW'(7 - k));
      exp_q.push_back(mdl_a[k]); exp_q.push_back(mdl_a[7 - k]);
      #1;
      for (int p = 0; p < 2; p++) begin
        want = exp_q.pop_front(); checks++;
        if (ifa.rdata[p*W +: W] !== want) begin
          failures++; $display("FAIL init_rd_a p%0d got=%h exp=%h", p, ifa.rdata[p*W +: W], want);
        end
      end
      checks++;
      if (ifa.rvld !== 2'b11) begin failures++; $display("FAIL init_rvld_a got=%b exp=11", ifa.rvld); end
      tick();
    end
    clr_a();
    for (int k = 0; k < 6; k++) begin
      set_rd_b(0, AW'(k)); set_rd_b(1, AW'(5 - k));
      exp_q.push_back(mdl_b[k]); exp_q.push_back(mdl_b[5 - k]);
      tick();
      for (int p = 0; p < 2; p++) begin
        want = exp_q.pop_front(); checks++;
        if (ifb.rdata[p*W +: W] !== want) begin
          failures++; $display("FAIL init_rd_b p%0d got=%h exp=%h", p, ifb.rdata[p*W +: W], want);
        end
      end
      checks++;
      if (ifb.rvld !== 2'b11) begin failures++; $display("FAIL init_rvld_b got=%b exp=11", ifb.rvld); end
    end
    clr_b();
  endtask

  task automatic test_collision();
    logic [W-1:0] want;
    clr_a();
    set_wr_a(0, 3'd3, 32'hA); set_wr_a(1, 3'd3, 32'hB);
    set_rd_a(0, 3'd3); set_rd_a(1, 3'd2);
    exp_q.push_back(32'hB); exp_q.push_back(mdl_a[2]);
    #1;
    for (int p = 0; p < 2; p++) begin
      want = exp_q.pop_front(); checks++;
      if (ifa.rdata[p*W +: W] !== want) begin
        failures++; $display("FAIL coll_bypass p%0d got=%h exp=%h", p, ifa.rdata[p*W +: W], want);
      end
    end
    tick();
    mdl_a[3] = 32'hB;
    clr_a();
    set_rd_a(0, 3'd3); set_rd_a(1, 3'd4);
    exp_q.push_back(mdl_a[3]); exp_q.push_back(mdl_a[4]);
    #1;
    for (int p = 0; p < 2; p++) begin
      want = exp_q.pop_front(); checks++;
      if (ifa.rdata[p*W +: W] !== want) begin
        failures++; $display("FAIL coll_mem p%0d got=%h exp=%h", p, ifa.rdata[p*W +: W], want);
      end
    end
    tick();
    clr_a();
  endtask

  task automatic test_bypass();
    logic [W-1:0] want;
    clr_a();
    set_wr_a(0, 3'd5, 32'h1);
    tick();
    mdl_a[5] = 32'h1;
    clr_a();
    set_wr_a(0, 3'd5, 32'h7); set_rd_a(0, 3'd5); set_rd_a(1, 3'd4);
    exp_q.push_back(32'h7); exp_q.push_back(mdl_a[4]);
    #1;
    for (int p = 0; p < 2; p++) begin
      want = exp_q.pop_front(); checks++;
      if (ifa.rdata[p*W +: W] !== want) begin
        failures++; $display("FAIL bypass_a p%0d got=%h exp=%h", p, ifa.rdata[p*W +: W], want);
      end
    end
    tick();
    mdl_a[5] = 32'h7;
    clr_a();
    set_rd_a(0, 3'd5);
    exp_q.push_back(mdl_a[5]);
    #1;
    want = exp_q.pop_front(); checks++;
    if (ifa.rdata[W-1:0] !== want) begin
      failures++; $display("FAIL bypass_a_after got=%h exp=%h", ifa.rdata[W-1:0], want);
    end
    tick();
    clr_a();

    clr_b();
    set_wr_b(0, 3'd5, 32'h1);
    tick();
    mdl_b[5] = 32'h1;
    clr_b();
    set_wr_b(0, 3'd5, 32'h7); set_rd_b(0, 3'd5);
    exp_q.push_back(mdl_b[5]);
    tick();
    mdl_b[5] = 32'h7;
    want = exp_q.pop_front(); checks++;
    if (ifb.rdata[W-1:0] !== want || ifb.rvld[0] !== 1'b1) begin
      failures++; $display("FAIL nobypass_b got=%h/%b exp=%h/1", ifb.rdata[W-1:0], ifb.rvld[0], want);
    end
    clr_b();
    set_rd_b(0, 3'd5);
    exp_q.push_back(mdl_b[5]);
    tick();
    want = exp_q.pop_front(); checks++;
    if (ifb.rdata[W-1:0] !== want) begin
      failures++; $display("FAIL nobypass_b_after got=%h exp=%h", ifb.rdata[W-1:0], want);
    end
    clr_b();
  endtask

  task automatic test_range();
    logic [W-1:0] want;
    logic [W-1:0] old0, old1;
    clr_b();
    set_wr_b(0, 3'd7, 32'h99); set_wr_b(1, 3'd6, 32'h98);
    tick();
    clr_b();
    for (int k = 0; k < 4; k++) begin
      if (k < 3) begin
        set_rd_b(0, AW'(2*k)); set_rd_b(1, AW'(2*k + 1));
        exp_q.push_back(mdl_b[2*k]); exp_q.push_back(mdl_b[2*k + 1]);
      end else begin
        set_rd_b(0, 3'd7); set_rd_b(1, 3'd6);
        exp_q.push_back('0); exp_q.push_back('0);
      end
      tick();
      for (int p = 0; p < 2; p++) begin
        want = exp_q.pop_front(); checks++;
        if (ifb.rdata[p*W +: W] !== want) begin
          failures++; $display("FAIL range_rd_b k%0d p%0d got=%h exp=%h", k, p, ifb.rdata[p*W +: W], want);
        end
      end
    end
    clr_b();
    set_rd_b(0, 3'd0); set_rd_b(1, 3'd1);
    old0 = mdl_b[0]; old1 = mdl_b[1];
    tick();
    for (int h = 0; h < 2; h++) begin
      clr_b();
      ifb.ra = {3'd3, 3'd2};
      set_wr_b(0, 3'd0, 32'h55 + h); set_wr_b(1, 3'd1, 32'h66 + h);
      exp_q.push_back(old0); exp_q.push_back(old1);
      tick();
      mdl_b[0] = 32'h55 + h; mdl_b[1] = 32'h66 + h;
      for (int p = 0; p < 2; p++) begin
        want = exp_q.pop_front(); checks++;
        if (ifb.rdata[p*W +: W] !== want) begin
          failures++; $display("FAIL hold_b h%0d p%0d got=%h exp=%h", h, p, ifb.rdata[p*W +: W], want);
        end
      end
      checks++;
      if (ifb.rvld !== 2'b00) begin failures++; $display("FAIL hold_rvld_b got=%b exp=00", ifb.rvld); end
    end
    clr_b();
  endtask

  task automatic fill_a(input logic [W-1:0] base);
    for (int k = 0; k < 4; k++) begin
      clr_a();
      set_wr_a(0, AW'(2*k), base + 2*k + 1); set_wr_a(1, AW'(2*k + 1), base + 2*k + 2);
      tick();
      mdl_a[2*k] = base + 2*k + 1; mdl_a[2*k + 1] = base + 2*k + 2;
    end
    clr_a();
  endtask

  task automatic test_soft_clear();
    int n;
    logic [W-1:0] want;
    fill_a('0);
    for (int k = 0; k < 4; k++) begin
      set_rd_a(0, AW'(2*k)); set_rd_a(1, AW'(2*k + 1));
      exp_q.push_back(mdl_a[2*k]); exp_q.push_back(mdl_a[2*k + 1]);
      #1;
      for (int p = 0; p < 2; p++) begin
        want = exp_q.pop_front(); checks++;
        if (ifa.rdata[p*W +: W] !== want) begin
          failures++; $display("FAIL fill_rd_a p%0d got=%h exp=%h", p, ifa.rdata[p*W +: W], want);
        end
      end
      tick();
    end
    clr_a();
    ifa.init_req = 1'b1;
    tick();
    ifa.init_req = 1'b0;
    n = 0;
    for (int c = 0; c < 20; c++) begin
      clr_a();
      #1;
      if (ifa.busy !== 1'b1) break;
      n++;
      set_wr_a(0, AW'(c % 8), 32'hFF); set_wr_a(1, AW'((c + 3) % 8), 32'hEE);
      ifa.ren = 2'b11;
      #1;
      checks++;
      if (ifa.rvld !== 2'b00 || ifa.rdata !== '0) begin
        failures++; $display("FAIL clear_out_a rvld=%b rdata=%h exp=0", ifa.rvld, ifa.rdata);
      end
      tick();
    end
    checks++;
    if (n != 8) begin failures++; $display("FAIL clear_len_a got=%0d exp=8", n); end
    for (int i = 0; i < 8; i++) mdl_a[i] = IV_A;
    clr_a();
    for (int k = 0; k < 4; k++) begin
      set_rd_a(0, AW'(2*k)); set_rd_a(1, AW'(2*k + 1));
      exp_q.push_back(mdl_a[2*k]); exp_q.push_back(mdl_a[2*k + 1]);
      #1;
      for (int p = 0; p < 2; p++) begin
        want = exp_q.pop_front(); checks++;
        if (ifa.rdata[p*W +: W] !== want) begin
          failures++; $display("FAIL clear_rd_a p%0d got=%h exp=%h", p, ifa.rdata[p*W +: W], want);
        end
      end
      tick();
    end
    clr_a();
  endtask

  task automatic test_restart();
    int n;
    logic [W-1:0] want;
    fill_a(32'h100);
    ifa.init_req = 1'b1; tick(); ifa.init_req = 1'b0;
    tick(); tick(); tick(); tick();
    ifa.init_req = 1'b1; tick(); ifa.init_req = 1'b0;
    n = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (ifa.busy !== 1'b1) break;
      n++;
      tick();
    end
    checks++;
    if (n != 8) begin failures++; $display("FAIL restart_len_a got=%0d exp=8", n); end

    fill_a(32'h200);
    ifa.init_req = 1'b1; tick(); ifa.init_req = 1'b0;
    tick(); tick();
    rst_a = 1'b0; tick(); rst_a = 1'b1;
    n = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (ifa.busy !== 1'b1) break;
      n++;
      tick();
    end
    checks++;
    if (n != 8) begin failures++; $display("FAIL rst_restart_len_a got=%0d exp=8", n); end
    for (int i = 0; i < 8; i++) mdl_a[i] = IV_A;
    for (int k = 0; k < 4; k++) begin
      set_rd_a(0, AW'(2*k)); set_rd_a(1, AW'(2*k + 1));
      exp_q.push_back(mdl_a[2*k]); exp_q.push_back(mdl_a[2*k + 1]);
      #1;
      for (int p = 0; p < 2; p++) begin
        want = exp_q.pop_front(); checks++;
        if (ifa.rdata[p*W +: W] !== want) begin
          failures++; $display("FAIL restart_rd_a p%0d got=%h exp=%h", p, ifa.rdata[p*W +: W], want);
        end
      end
      tick();
    end
    clr_a();
  endtask

  task automatic test_back_to_back();
    logic [1:0]    wen, ren;
    logic [AW-1:0] wa [2];
    logic [AW-1:0] ra [2];
    logic [W-1:0]  wd [2];
    logic [W-1:0]  want, e;
    logic [W-1:0]  last_b [2];
    for (int c = 0; c < 40; c++) begin
      clr_a();
      wen = 2'($urandom_range(0, 3)); ren = 2'($urandom_range(0, 3));
      for (int j = 0; j < 2; j++) begin
        wa[j] = AW'($urandom_range(0, 7)); ra[j] = AW'($urandom_range(0, 7));
        wd[j] = $urandom;
        if (wen[j]) set_wr_a(j, wa[j], wd[j]);
        ifa.ra[j*AW +: AW] = ra[j];
      end
      ifa.ren = ren;
      for (int i = 0; i < 2; i++) begin
        e = mdl_a[ra[i]];
        for (int j = 0; j < 2; j++) if (wen[j] && wa[j] == ra[i]) e = wd[j];
        exp_q.push_back(e);
      end
      #1;
      for (int p = 0; p < 2; p++) begin
        want = exp_q.pop_front(); checks++;
        if (ifa.rdata[p*W +: W] !== want) begin
          failures++; $display("FAIL b2b_a c%0d p%0d got=%h exp=%h", c, p, ifa.rdata[p*W +: W], want);
        end
      end
      checks++;
      if (ifa.rvld !== ren) begin failures++; $display("FAIL b2b_rvld_a got=%b exp=%b", ifa.rvld, ren); end
      tick();
      for (int j = 0; j < 2; j++) if (wen[j]) mdl_a[wa[j]] = wd[j];
    end
    clr_a();

    for (int c = 0; c < 40; c++) begin
      clr_b();
      wen = 2'($urandom_range(0, 3));
      ren = (c == 0) ? 2'b11 : 2'($urandom_range(0, 3));
      for (int j = 0; j < 2; j++) begin
        wa[j] = AW'($urandom_range(0, 7)); ra[j] = AW'($urandom_range(0, 7));
        wd[j] = $urandom;
        if (wen[j]) set_wr_b(j, wa[j], wd[j]);
        ifb.ra[j*AW +: AW] = ra[j];
      end
      ifb.ren = ren;
      for (int i = 0; i < 2; i++) begin
        if (ren[i]) last_b[i] = (ra[i] < 3'd6) ? mdl_b[ra[i]] : '0;
        exp_q.push_back(last_b[i]);
      end
      tick();
      for (int p = 0; p < 2; p++) begin
        want = exp_q.pop_front(); checks++;
        if (ifb.rdata[p*W +: W] !== want) begin
          failures++; $display("FAIL b2b_b c%0d p%0d got=%h exp=%h", c, p, ifb.rdata[p*W +: W], want);
        end
      end
      checks++;
      if (ifb.rvld !== ren) begin failures++; $display("FAIL b2b_rvld_b got=%b exp=%b", ifb.rvld, ren); end
      for (int j = 0; j < 2; j++) if (wen[j] && wa[j] < 3'd6) mdl_b[wa[j]] = wd[j];
    end
    clr_b();
  endtask

  initial begin
    rst_a = 1'b0; rst_b = 1'b0;
    clr_a(); clr_b();
    test_reset();
    test_collision();
    test_bypass();
    test_range();
    test_soft_clear();
    test_restart();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end
endmodule
